// File: rtl/mini_cpu_datapath.sv
// Execution datapath of the mini CPU: a 16-entry register memory, an ALU and a
// display-result register, sequenced IDLE -> DECODE -> CALC -> STORE.
module mini_cpu_datapath #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [2:0]        opcode,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [ADDR_W-1:0] addr2,
    input  logic [6:0]        addr3_imm,
    output logic              busy,
    output logic              decoded,
    output logic              calculated,
    output logic              stored,
    output logic [DATA_W-1:0] result,
    output logic              result_valid
);

    localparam int NREG = 1 << ADDR_W;

    localparam logic [2:0] OP_LOAD    = 3'b000;
    localparam logic [2:0] OP_ADD     = 3'b001;
    localparam logic [2:0] OP_ADDI    = 3'b010;
    localparam logic [2:0] OP_SUB     = 3'b011;
    localparam logic [2:0] OP_SUBI    = 3'b100;
    localparam logic [2:0] OP_MUL     = 3'b101;
    localparam logic [2:0] OP_CLEAR   = 3'b110;
    localparam logic [2:0] OP_DISPLAY = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DECODE,
        S_CALC,
        S_STORE
    } state_t;

    state_t              state_q, state_d;
    logic [2:0]          op_q, op_d;
    logic [ADDR_W-1:0]   a1_q, a1_d;
    logic [ADDR_W-1:0]   a2_q, a2_d;
    logic [6:0]          f3_q, f3_d;
    logic [DATA_W-1:0]   opa_q, opa_d;
    logic [DATA_W-1:0]   opb_q, opb_d;
    logic [DATA_W-1:0]   result_q, result_d;
    logic                valid_q, valid_d;
    logic [DATA_W-1:0]   regs_q [NREG];
    logic [DATA_W-1:0]   regs_d [NREG];

    logic [DATA_W-1:0]   mag_ext;
    logic [DATA_W-1:0]   imm_val;
    logic [DATA_W-1:0]   mul_lo;
    logic [DATA_W-1:0]   alu_out;
    logic [ADDR_W-1:0]   rd_a_addr;
    logic                wr_en;
    logic                clr_all;

    // Sign-magnitude immediate; a negative zero collapses naturally to 0.
    assign mag_ext = {{(DATA_W-6){1'b0}}, f3_q[5:0]};
    assign imm_val = f3_q[6] ? ({DATA_W{1'b0}} - mag_ext) : mag_ext;

    // The low half of a two's complement product is sign-agnostic.
    assign mul_lo = opa_q * opb_q;

    assign rd_a_addr = (op_q == OP_DISPLAY) ? a1_q : a2_q;

    always_comb begin
        alu_out = '0;
        case (op_q)
            OP_LOAD:    alu_out = imm_val;
            OP_ADD:     alu_out = opa_q + opb_q;
            OP_ADDI:    alu_out = opa_q + imm_val;
            OP_SUB:     alu_out = opa_q - opb_q;
            OP_SUBI:    alu_out = opa_q - imm_val;
            OP_MUL:     alu_out = mul_lo;
            OP_CLEAR:   alu_out = '0;
            OP_DISPLAY: alu_out = opa_q;
            default:    alu_out = '0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a1_d     = a1_q;
        a2_d     = a2_q;
        f3_d     = f3_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        result_d = result_q;
        valid_d  = valid_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d    = opcode;
                    a1_d    = addr1;
                    a2_d    = addr2;
                    f3_d    = addr3_imm;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                opa_d   = regs_q[rd_a_addr];
                opb_d   = regs_q[f3_q[ADDR_W-1:0]];
                state_d = S_CALC;
            end
            S_CALC: begin
                result_d = alu_out;
                valid_d  = (op_q != OP_CLEAR);
                state_d  = S_STORE;
            end
            S_STORE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Write-back takes the value captured in result during CALC.
    assign wr_en   = (state_q == S_STORE) && (op_q != OP_CLEAR) && (op_q != OP_DISPLAY);
    assign clr_all = (state_q == S_STORE) && (op_q == OP_CLEAR);

    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
            assign regs_d[gi] = clr_all ? '0 :
                                (wr_en && (a1_q == ADDR_W'(gi))) ? result_q :
                                regs_q[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            a1_q     <= '0;
            a2_q     <= '0;
            f3_q     <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            result_q <= '0;
            valid_q  <= 1'b0;
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a1_q     <= a1_d;
            a2_q     <= a2_d;
            f3_q     <= f3_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            result_q <= result_d;
            valid_q  <= valid_d;
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    assign busy         = (state_q != S_IDLE);
    assign decoded      = (state_q == S_DECODE);
    assign calculated   = (state_q == S_CALC);
    assign stored       = (state_q == S_STORE);
    assign result       = result_q;
    assign result_valid = valid_q;

endmodule

// File: tb/tb_mini_cpu_datapath.sv
// Bench for mini_cpu_datapath: table of instructions with hand-derived results,
// a result scoreboard, and hand-written sequences for busy-start and mid-reset.
module tb_mini_cpu_datapath;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  opcode;
    logic [3:0]  addr1;
    logic [3:0]  addr2;
    logic [6:0]  addr3_imm;
    logic        busy;
    logic        decoded;
    logic        calculated;
    logic        stored;
    logic [15:0] result;
    logic        result_valid;

    int total = 0;
    int bad   = 0;

    mini_cpu_datapath #(.DATA_W(16), .ADDR_W(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .opcode       (opcode),
        .addr1        (addr1),
        .addr2        (addr2),
        .addr3_imm    (addr3_imm),
        .busy         (busy),
        .decoded      (decoded),
        .calculated   (calculated),
        .stored       (stored),
        .result       (result),
        .result_valid (result_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [3:0]  a1;
        logic [3:0]  a2;
        logic [6:0]  f3;
        logic        inject;
        logic [15:0] res;
        logic        vld;
    } vec_t;

    typedef struct {
        logic [15:0] res;
        logic        vld;
    } exp_t;

    vec_t vecs [18];
    exp_t sb [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Drives one instruction and checks its pulse train; the result is popped
    // from the scoreboard in the STORE cycle, when it has just been updated.
    task automatic run_instr(input logic [2:0] op, input logic [3:0] a1, input logic [3:0] a2,
                             input logic [6:0] f3, input logic inject,
                             input logic [15:0] exp_res, input logic exp_vld);
        exp_t e;
        @(negedge clk);
        start = 1'b1; opcode = op; addr1 = a1; addr2 = a2; addr3_imm = f3;
        e.res = exp_res; e.vld = exp_vld;
        sb.push_back(e);
        @(negedge clk);
        if (inject) begin
            start = 1'b1; opcode = 3'b000; addr1 = 4'd15; addr2 = 4'd0; addr3_imm = 7'h05;
        end else begin
            start = 1'b0;
        end
        chk("decoded_n1", {31'b0, decoded}, 32'd1);
        chk("calc_n1", {31'b0, calculated}, 32'd0);
        chk("busy_n1", {31'b0, busy}, 32'd1);
        @(negedge clk);
        start = 1'b0;
        chk("calc_n2", {31'b0, calculated}, 32'd1);
        chk("decoded_n2", {31'b0, decoded}, 32'd0);
        chk("busy_n2", {31'b0, busy}, 32'd1);
        @(negedge clk);
        chk("stored_n3", {31'b0, stored}, 32'd1);
        chk("busy_n3", {31'b0, busy}, 32'd1);
        if (sb.size() == 0) begin
            total++; bad++;
            $display("FAIL scoreboard_empty: got 0 entries expected 1");
        end else begin
            e = sb.pop_front();
            chk("result", {16'b0, result}, {16'b0, e.res});
            chk("result_valid", {31'b0, result_valid}, {31'b0, e.vld});
        end
        @(negedge clk);
        chk("busy_idle", {31'b0, busy}, 32'd0);
        chk("stored_idle", {31'b0, stored}, 32'd0);
        chk("decoded_idle", {31'b0, decoded}, 32'd0);
        $display("instr op=%0d a1=%0d a2=%0d f3=%02h inject=%0d -> result=%04h valid=%0d",
                 op, a1, a2, f3, inject, result, result_valid);
    endtask

    initial begin
        vecs[0]  = '{3'd7, 4'd5, 4'd0, 7'h00,       1'b0, 16'h0000, 1'b1}; // DISPLAY R5
        vecs[1]  = '{3'd0, 4'd1, 4'd0, 7'b0011001,  1'b0, 16'h0019, 1'b1}; // LOAD R1 +25
        vecs[2]  = '{3'd0, 4'd2, 4'd0, 7'b1001010,  1'b0, 16'hFFF6, 1'b1}; // LOAD R2 -10
        vecs[3]  = '{3'd1, 4'd3, 4'd1, 7'h02,       1'b0, 16'h000F, 1'b1}; // ADD R3=R1+R2
        vecs[4]  = '{3'd7, 4'd3, 4'd0, 7'h00,       1'b0, 16'h000F, 1'b1}; // DISPLAY R3
        vecs[5]  = '{3'd3, 4'd4, 4'd2, 7'h01,       1'b0, 16'hFFDD, 1'b1}; // SUB R4=R2-R1
        vecs[6]  = '{3'd4, 4'd4, 4'd4, 7'b1111111,  1'b0, 16'h001C, 1'b1}; // SUBI R4-(-63)
        vecs[7]  = '{3'd5, 4'd5, 4'd1, 7'h01,       1'b1, 16'h0271, 1'b1}; // MUL R5=R1*R1, start while busy
        vecs[8]  = '{3'd2, 4'd6, 4'd2, 7'b1000000,  1'b0, 16'hFFF6, 1'b1}; // ADDI R6=R2+(-0)
        vecs[9]  = '{3'd0, 4'd1, 4'd0, 7'b0111111,  1'b0, 16'h003F, 1'b1}; // LOAD R1 +63
        vecs[10] = '{3'd5, 4'd1, 4'd1, 7'h01,       1'b0, 16'h0F81, 1'b1}; // MUL R1*R1 = 3969
        vecs[11] = '{3'd5, 4'd1, 4'd1, 7'h01,       1'b0, 16'h5F01, 1'b1}; // 3969^2 low 16
        vecs[12] = '{3'd5, 4'd1, 4'd1, 7'h01,       1'b0, 16'hBE01, 1'b1}; // wraps
        vecs[13] = '{3'd1, 4'd4, 4'd4, 7'h04,       1'b0, 16'h0038, 1'b1}; // ADD R4=R4+R4
        vecs[14] = '{3'd7, 4'd4, 4'd0, 7'h00,       1'b1, 16'h0038, 1'b1}; // DISPLAY R4, start while busy
        vecs[15] = '{3'd6, 4'd0, 4'd0, 7'h00,       1'b0, 16'h0000, 1'b0}; // CLEAR
        vecs[16] = '{3'd7, 4'd1, 4'd0, 7'h00,       1'b0, 16'h0000, 1'b1}; // DISPLAY R1
        vecs[17] = '{3'd7, 4'd15, 4'd0, 7'h00,      1'b0, 16'h0000, 1'b1}; // DISPLAY R15 (never written by injects)

        rst_n = 1'b0; start = 1'b0; opcode = '0; addr1 = '0; addr2 = '0; addr3_imm = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_pulses", {29'b0, decoded, calculated, stored}, 32'd0);
        chk("rst_result", {16'b0, result}, 32'd0);
        chk("rst_valid", {31'b0, result_valid}, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 18; i++) begin
            run_instr(vecs[i].op, vecs[i].a1, vecs[i].a2, vecs[i].f3, vecs[i].inject,
                      vecs[i].res, vecs[i].vld);
        end

        // Result holds across idle cycles.
        run_instr(3'd0, 4'd8, 4'd0, 7'b0010001, 1'b0, 16'h0011, 1'b1);
        repeat (4) @(negedge clk);
        chk("hold_result", {16'b0, result}, 32'h0011);
        chk("hold_valid", {31'b0, result_valid}, 32'd1);
        $display("hold check: result=%04h valid=%0d", result, result_valid);

        // Reset during CALC of ADD R9=R8+R8 aborts with no write-back.
        @(negedge clk);
        start = 1'b1; opcode = 3'd1; addr1 = 4'd9; addr2 = 4'd8; addr3_imm = 7'h08;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("abort_in_calc", {31'b0, calculated}, 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_stored", {31'b0, stored}, 32'd0);
        chk("abort_result", {16'b0, result}, 32'd0);
        chk("abort_valid", {31'b0, result_valid}, 32'd0);
        $display("mid-calc reset: busy=%0d result=%04h valid=%0d", busy, result, result_valid);
        @(negedge clk);
        chk("abort_idle", {31'b0, decoded}, 32'd0);
        run_instr(3'd7, 4'd9, 4'd0, 7'h00, 1'b0, 16'h0000, 1'b1);
        run_instr(3'd7, 4'd8, 4'd0, 7'h00, 1'b0, 16'h0000, 1'b1);

        if (sb.size() != 0) begin
            total++; bad++;
            $display("FAIL scoreboard_leftover: got %0d entries expected 0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mini_cpu_datapath.md
Name: mini_cpu_datapath

Overview:
- Execution datapath of the mini CPU: a 16x16-bit register memory, an ALU and a display-result register, sequenced by a small control FSM.
- The front-end FSM latches an instruction (opcode plus operand switches) and pulses start.
- The block decodes, computes, writes back and presents the 16-bit result to the LCD driver.
- It reports progress with decoded, calculated and stored pulses.

Parameters:
- DATA_W, 16, data width of registers, ALU and result.
- ADDR_W, 4, register address width (16 registers).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  one-cycle request to execute the instruction on the inputs below.
- opcode  in  3  operation code, sampled on start.
- addr1  in  4  destination register (source register for DISPLAY), sampled on start.
- addr2  in  4  first source register, sampled on start.
- addr3_imm  in  7  shared field, sampled on start:
  - register ops: addr3 = [3:0].
  - immediate ops: bit6 = sign, [5:0] = magnitude.
- busy  out  1  high from the cycle after an accepted start until the stored pulse cycle, inclusive.
- decoded  out  1  one-cycle pulse, DECODE state.
- calculated  out  1  one-cycle pulse, CALC state.
- stored  out  1  one-cycle pulse, STORE state.
- result  out  16  last computed/displayed value, two's complement.
- result_valid  out  1  set by the first completed instruction after reset; held until reset or CLEAR.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - all 16 registers = 0.
  - result = 0; result_valid = 0; busy = 0; all pulses = 0.
  - FSM = IDLE.
  - Reset mid-instruction aborts it with no register write.
- FSM states: IDLE -> DECODE -> CALC -> STORE -> IDLE, one cycle each.
- IDLE:
  - start=1 latches opcode, addr1, addr2 and addr3_imm into internal regs and goes to DECODE.
  - start while busy is ignored and not queued.
- DECODE: decoded=1; operands are read from the register memory (combinational read of the latched addresses).
- CALC:
  - calculated=1; the ALU output is registered into result.
  - For every opcode except CLEAR, result_valid is set to 1.
- STORE:
  - stored=1; write-back happens at the end of this cycle.
  - Returns to IDLE; a start in the next cycle is accepted.
- Latency: start at edge N gives decoded in cycle N+1, calculated in N+2, stored in N+3.
- result updates at the end of cycle N+2. Write-back is visible to an instruction started at N+4.
- Immediate: imm = sign ? -mag : +mag, sign-extended to 16 bits. Range -63..+63; "-0" = 0.
- Opcodes:
  - 000 LOAD: R[addr1] = imm.
  - 001 ADD: R[addr1] = R[addr2] + R[addr3].
  - 010 ADDI: R[addr1] = R[addr2] + imm.
  - 011 SUB: R[addr1] = R[addr2] - R[addr3].
  - 100 SUBI: R[addr1] = R[addr2] - imm.
  - 101 MUL: R[addr1] = low 16 bits of signed R[addr2] * R[addr3].
  - 110 CLEAR: all 16 registers = 0 at STORE; result = 0; result_valid = 0.
  - 111 DISPLAY: result = R[addr1]; no write.
- Arithmetic is 16-bit two's complement and wraps silently; there is no overflow flag.
- Operand reads use the values present at DECODE. Same-register source and destination (e.g. ADD R1,R1,R1) uses the old value and writes the new one.
- Only one register is written per instruction (except CLEAR).
- Between instructions, result holds its value.

Test Plan:
- Reset, then DISPLAY R5 -> result=0, result_valid=1; pulses at +1/+2/+3 cycles; busy spans 3 cycles.
- LOAD R1 with imm=+25 (addr3_imm=7'b0011001), then LOAD R2 with -10 (7'b1001010), then ADD R3=R1+R2, then DISPLAY R3 -> result=15 (0x000F).
- SUB R4=R2-R1 -> result=-35 (0xFFDD); SUBI R4=R4-(-63) -> result=28. MUL of R1=25 by R1 -> 625 (0x0271).
- Overflow: LOAD R1 with +63, then MUL chain R1=R1*R1 three times -> the third result is the low 16 bits of the true product, wrapping silently with no error.
- start asserted during busy -> ignored, no extra pulses. CLEAR -> all registers read 0; result=0; result_valid=0.
- Reset asserted in CALC cycle of ADD -> no write-back, outputs reset, next DISPLAY of the destination register reads 0.
